// File: rtl/mgmt_irq_pkg.sv
// Shared constants and types for the management SoC interrupt controller.
// Register map, STATUS layout, FSM encodings and the priority helper.
package mgmt_irq_pkg;

  localparam int IDW = 5;

  localparam logic [4:0] A_ENABLE = 5'h00;
  localparam logic [4:0] A_EDGE   = 5'h04;
  localparam logic [4:0] A_PEND   = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C;
  localparam logic [4:0] A_FORCE  = 5'h10;

  localparam int ST_BUSY  = 8;
  localparam int ST_STATE = 6;
  localparam int ST_ID    = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_SERVICE = 2'd2
  } irq_state_e;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_ACK  = 1'b1
  } bus_state_e;

  // Lowest set bit wins; scanning downward lets the last hit be the lowest.
  function automatic logic [IDW-1:0] lowest_idx(input logic [31:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = IDW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mgmt_irq_ctrl_sync.sv
// Per-source synchroniser chain followed by a rising-edge detector.
// s_o is the synchronised level, rise_o flags its 0->1 transition.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      s_q    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~s_q;

endmodule

// File: rtl/mgmt_irq_ctrl.sv
// Interrupt controller: capture, mask, prioritise and present one
// request to the CPU with a claim/EOI handshake and a small reg bus.
module mgmt_irq_ctrl
  import mgmt_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               reg_cs,
  input  logic               reg_we,
  input  logic [4:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_ack,
  output logic               cpu_irq,
  output logic [IDW-1:0]     cpu_irq_id,
  input  logic               cpu_claim,
  input  logic               cpu_eoi
);

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clock  (clock),
      .resetb (resetb),
      .d_i    (irq_src[g]),
      .s_o    (s[g]),
      .rise_o (rise[g])
    );
  end

  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] epend_q, epend_d;
  irq_state_e         state_q, state_d;
  logic               irq_q, irq_d;
  logic [IDW-1:0]     id_q, id_d;
  bus_state_e         bus_q, bus_d;
  logic               ack_q;
  logic [31:0]        rdata_q, rd_val;

  logic [NUM_IRQ-1:0] pend, act, id_oh;
  logic [NUM_IRQ-1:0] wdat, set_v, clr_v;
  logic [IDW-1:0]     winner;
  logic               acc, wr, rd, act_id, claim_fire;
  logic               wr_en, wr_edge, wr_pend, wr_force;

  assign pend   = (epend_q & edge_q) | (s & ~edge_q);
  assign act    = pend & en_q;
  assign winner = lowest_idx(32'(act));

  always_comb begin
    id_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_oh[i] = (id_q == IDW'(i));
    end
  end

  assign act_id     = |(act & id_oh);
  assign claim_fire = (state_q == S_PRESENT) & cpu_claim;

  assign acc      = (bus_q == B_IDLE) & reg_cs;
  assign wr       = acc & reg_we;
  assign rd       = acc & ~reg_we;
  assign wdat     = reg_wdata[NUM_IRQ-1:0];
  assign wr_en    = wr & (reg_addr == A_ENABLE);
  assign wr_edge  = wr & (reg_addr == A_EDGE);
  assign wr_pend  = wr & (reg_addr == A_PEND);
  assign wr_force = wr & (reg_addr == A_FORCE);

  // Sets are OR-ed in after clears so a fresh edge is never lost.
  assign clr_v = (wr_pend ? wdat : '0)
               | (claim_fire ? (id_oh & edge_q) : '0);
  assign set_v = (rise & edge_q)
               | (wr_force ? wdat : '0);

  always_comb begin
    en_d    = wr_en ? wdat : en_q;
    edge_d  = wr_edge ? wdat : edge_q;
    epend_d = (epend_q & ~clr_v) | set_v;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (reg_addr == A_ENABLE): rd_val = 32'(en_q);
      (reg_addr == A_EDGE):   rd_val = 32'(edge_q);
      (reg_addr == A_PEND):   rd_val = 32'(pend);
      (reg_addr == A_STATUS): begin
        rd_val = 32'({(state_q != S_IDLE), state_q, 1'b0, id_q});
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    unique case (state_q)
      S_IDLE: begin
        if (|act) begin
          state_d = S_PRESENT;
          irq_d   = 1'b1;
          id_d    = winner;
        end
      end
      S_PRESENT: begin
        if (cpu_claim) begin
          state_d = S_SERVICE;
          irq_d   = 1'b0;
        end else if (!act_id) begin
          state_d = S_IDLE;
          irq_d   = 1'b0;
        end
      end
      S_SERVICE: begin
        if (cpu_eoi) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus_d = bus_q;
    unique case (bus_q)
      B_IDLE:  if (reg_cs) bus_d = B_ACK;
      B_ACK:   bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      en_q    <= '0;
      edge_q  <= '0;
      epend_q <= '0;
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      bus_q   <= B_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      edge_q  <= edge_d;
      epend_q <= epend_d;
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      bus_q   <= bus_d;
      ack_q   <= acc;
      rdata_q <= rd ? rd_val : '0;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_ack    = ack_q;
  assign cpu_irq    = irq_q;
  assign cpu_irq_id = id_q;

  logic unused_ok;
  assign unused_ok = ^reg_wdata;

endmodule
